// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register for the RV32I core.
// Single outstanding imem request, skid buffer for decode stalls, redirect/flush handling.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_req,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_valid,
  input  logic             stall_d,
  input  logic             flush_d,
  input  logic             pc_src_e,
  input  logic [WIDTH-1:0] pc_target_e,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d
);

  localparam logic [WIDTH-1:0] NopInstr = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] AlignMask = {{(WIDTH-2){1'b1}}, 2'b00};
  localparam logic [WIDTH-1:0] ResetPcAligned = RESET_PC & AlignMask;
  localparam logic [WIDTH-1:0] Four = WIDTH'(4);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDiscard} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_f_q, pc_f_d;
  logic [WIDTH-1:0] skid_instr_q, skid_pc_q;
  logic             skid_we, load_mem, load_skid;

  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    skid_we   = 1'b0;
    load_mem  = 1'b0;
    load_skid = 1'b0;
    unique case (state_q)
      StReq: begin
        state_d = pc_src_e ? StDiscard : StWait;
      end
      StWait: begin
        if (pc_src_e) begin
          state_d = imem_valid ? StReq : StDiscard;
        end else if (imem_valid) begin
          pc_f_d = pc_f_q + Four;
          if (stall_d) begin
            skid_we = 1'b1;
            state_d = StHold;
          end else begin
            load_mem = 1'b1;
            state_d  = StReq;
          end
        end
      end
      StHold: begin
        if (pc_src_e) begin
          state_d = StReq;
        end else if (!stall_d) begin
          load_skid = 1'b1;
          state_d   = StReq;
        end
      end
      StDiscard: begin
        // A redirect coinciding with the drain still leaves nothing outstanding.
        if (imem_valid) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
    if (pc_src_e) pc_f_d = pc_target_e & AlignMask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StReq;
      pc_f_q       <= ResetPcAligned;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_f_q  <= pc_f_d;
      if (skid_we) begin
        skid_instr_q <= imem_rdata;
        skid_pc_q    <= pc_f_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NopInstr;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d    <= NopInstr;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (stall_d) begin
      instr_d    <= instr_d;
      pc_d       <= pc_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (load_mem) begin
      instr_d    <= imem_rdata;
      pc_d       <= pc_f_q;
      pc_plus4_d <= pc_f_q + Four;
      valid_d    <= 1'b1;
    end else if (load_skid) begin
      instr_d    <= skid_instr_q;
      pc_d       <= skid_pc_q;
      pc_plus4_d <= skid_pc_q + Four;
      valid_d    <= 1'b1;
    end else begin
      instr_d    <= NopInstr;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end
  end

  // Reset gates the strobe since the state already sits in StReq during reset.
  assign imem_req  = rst_n && (state_q == StReq);
  assign imem_addr = pc_f_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random stall/redirect traffic.
// The reference tracks program order and memory-request order, not the pipeline's internals.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] imem_addr, imem_rdata, pc_target_e, instr_d, pc_d, pc_plus4_d;
  logic        imem_req, imem_valid, stall_d, flush_d, pc_src_e, valid_d;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model and program-order reference state.
  bit          outstanding = 0;
  bit          stale = 0;
  int          cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          consumed = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] next_req_addr = '0;
  logic [31:0] exp_pc = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h0000_0093;
      32'h0000_0004: memf = 32'h0010_0113;
      default:       memf = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  // One clock cycle: entered mid-cycle, drives this cycle's inputs, returns at the next negedge.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] tgt, input bit fl);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (stale) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
      stale      = 0;
    end else if (outstanding) begin
      cnt--;
      if (cnt == 0) begin
        imem_valid  = 1'b1;
        imem_rdata  = memf(req_addr);
        outstanding = 0;
      end
    end
    if (imem_req) begin
      check("one_outstanding", 32'(outstanding), 32'd0);
      check("req_addr", imem_addr, next_req_addr);
      req_addr      = imem_addr;
      next_req_addr = imem_addr + 32'd4;
      outstanding   = 1;
      cnt           = $urandom_range(lat_lo, lat_hi);
    end
    stall_d     = st;
    flush_d     = fl | rd;
    pc_src_e    = rd;
    pc_target_e = tgt;
    if (valid_d && !st && !(fl | rd)) begin
      consumed++;
      check("order_pc", pc_d, exp_pc);
      check("order_instr", instr_d, memf(pc_d));
      check("order_plus4", pc_plus4_d, pc_d + 32'd4);
      exp_pc = pc_d + 32'd4;
    end else if (valid_d && fl && !rd) begin
      exp_pc = pc_d + 32'd4;  // flushed instruction is skipped
    end
    if (rd) begin
      exp_pc        = tgt & 32'hFFFF_FFFC;
      next_req_addr = tgt & 32'hFFFF_FFFC;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    pc_src_e   = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr_d, 32'h0000_0013);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_pc_d", pc_d, 32'd0);
    check("rst_plus4", pc_plus4_d, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    outstanding   = 0;
    stale         = 1;
    next_req_addr = 32'd0;
    exp_pc        = 32'd0;
    #1;
  endtask

  initial begin
    bit found;
    imem_valid  = 1'b0;
    imem_rdata  = '0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    pc_src_e    = 1'b0;
    pc_target_e = '0;
    @(negedge clk);
    do_reset();

    // Sequential fetch with 1-cycle memory.
    lat_lo = 1; lat_hi = 1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("seq_instr", instr_d, 32'h0000_0093);
    check("seq_pc", pc_d, 32'd0);
    check("seq_plus4", pc_plus4_d, 32'd4);
    check("seq_valid", 32'(valid_d), 32'd1);
    check("seq_addr", imem_addr, 32'd4);

    // Stall over the response for PC 8.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("hold_req", 32'(imem_req), 32'd0);
    check("hold_valid", 32'(valid_d), 32'd0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("skid_pc", pc_d, 32'd8);
    check("skid_instr", instr_d, memf(32'd8));
    check("skid_valid", 32'(valid_d), 32'd1);
    check("skid_next_req", 32'(imem_req), 32'd1);
    check("skid_next_addr", imem_addr, 32'd12);

    // Redirect while a 3-cycle response is outstanding.
    lat_lo = 3; lat_hi = 3;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 32'h0000_0103, 0);
    check("discard_req", 32'(imem_req), 32'd0);
    cycle(0, 0, 0, 0);
    lat_lo = 1; lat_hi = 1;
    cycle(0, 0, 0, 0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("redir_pc_d", pc_d, 32'h0000_0100);

    // Flush beats stall.
    cycle(1, 0, 0, 1);
    check("flush_instr", instr_d, 32'h0000_0013);
    check("flush_valid", 32'(valid_d), 32'd0);
    check("flush_pc_d", pc_d, 32'd0);

    // PC wrap.
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (valid_d && pc_d == 32'hFFFF_FFFC) begin
        found = 1;
        check("wrap_plus4", pc_plus4_d, 32'd0);
      end else begin
        cycle(0, 0, 0, 0);
      end
    end
    check("wrap_seen", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // Reset while waiting on a slow response.
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle(0, 0, 0, 0);
      if (outstanding && cnt == 3) found = 1;
    end
    check("wait_reached", 32'(found), 32'd1);
    do_reset();
    lat_lo = 1; lat_hi = 1;
    check("rerst_addr", imem_addr, 32'd0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("rerst_instr", instr_d, 32'h0000_0093);
    check("rerst_valid", 32'(valid_d), 32'd1);

    // Random traffic.
    lat_lo = 1; lat_hi = 3;
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      bit st, rd, fl;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 9) < 3);
      rd  = ($urandom_range(0, 19) == 0);
      fl  = st && ($urandom_range(0, 29) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cycle(st, rd, tgt, fl);
    end
    check("progress", 32'(consumed > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
